// File: rtl/dual_config_ctrl.sv
// Remote-update controller for dual-image configuration: reads status, writes image select, triggers reconfig.
// Optional WATCHDOG_KICK_EN adds wd_kick, which stretches into a 4-cycle RU_nRSTIMER pulse.
module dual_config_ctrl #(
  parameter int REG_W   = 41,
  parameter int SEL_LSB = 12,
  parameter int SEL_W   = 2,
  parameter int RD_LSB  = 30,
  parameter int RD_W    = 4,
  parameter int NC_DLY  = 7,
  parameter int NC_LEN  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [SEL_W-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RD_W-1:0]  rsp_data,
  output logic             rsp_err,
  output logic             busy,
  output logic             RU_CLK,
  output logic             RU_DIN,
  output logic             RU_SHIFTnLD,
  output logic             RU_CAPTnUPDT,
  output logic             RU_nCONFIG,
  output logic             RU_nRSTIMER,
  input  logic             RU_DOUT
`ifdef WATCHDOG_KICK_EN
  ,
  input  logic             wd_kick
`endif
);

  localparam int CMAX = (REG_W > NC_DLY) ? ((REG_W > NC_LEN) ? REG_W : NC_LEN)
                                         : ((NC_DLY > NC_LEN) ? NC_DLY : NC_LEN);
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(REG_W - 1);
  localparam logic [CW-1:0] DLY_LAST   = CW'(NC_DLY - 1);
  localparam logic [CW-1:0] NCFG_LAST  = CW'(NC_LEN - 1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_WRC = 2'b10;

  typedef enum logic [2:0] {IDLE, CAPT, SHIFT, UPDT, DLY, NCFG, RESP} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [REG_W-1:0] sr_q;
  logic [REG_W-1:0] sr_nxt;
  logic [1:0]       op_q;
  logic [RD_W-1:0]  rsp_data_q;
  logic             rsp_err_q;

  // One shift register serves both directions: DIN leaves from bit 0, DOUT enters at the top.
  assign sr_nxt = {RU_DOUT, sr_q[REG_W-1:1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      op_q       <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (cmd_valid) begin
          op_q  <= cmd_op;
          cnt_q <= '0;
          case (cmd_op)
            OP_RD:         state_q <= CAPT;
            OP_WR, OP_WRC: begin
              sr_q    <= REG_W'(cmd_sel) << SEL_LSB;
              state_q <= SHIFT;
            end
            default: begin
              rsp_data_q <= '0;
              rsp_err_q  <= 1'b1;
              state_q    <= RESP;
            end
          endcase
        end
        CAPT: state_q <= SHIFT;
        SHIFT: begin
          sr_q <= sr_nxt;
          if (cnt_q == SHIFT_LAST) begin
            cnt_q <= '0;
            if (op_q == OP_RD) begin
              rsp_data_q <= sr_nxt[RD_LSB +: RD_W];
              rsp_err_q  <= 1'b0;
              state_q    <= RESP;
            end else begin
              state_q <= UPDT;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        UPDT: begin
          cnt_q <= '0;
          if (op_q == OP_WRC) begin
            state_q <= DLY;
          end else begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end
        end
        DLY: begin
          if (cnt_q == DLY_LAST) begin
            cnt_q   <= '0;
            state_q <= NCFG;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        NCFG: begin
          if (cnt_q == NCFG_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: if (rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign rsp_valid    = (state_q == RESP);
  assign rsp_data     = (state_q == RESP) ? rsp_data_q : '0;
  assign rsp_err      = (state_q == RESP) && rsp_err_q;
  // Inverted clock lets the remote-update block sample mid-cycle.
  assign RU_CLK       = ~clk;
  assign RU_SHIFTnLD  = (state_q == SHIFT);
  assign RU_CAPTnUPDT = !((state_q == UPDT) || ((state_q == SHIFT) && (op_q != OP_RD)));
  assign RU_DIN       = (state_q == SHIFT) && (op_q != OP_RD) && sr_q[0];
  assign RU_nCONFIG   = (state_q == NCFG);

`ifdef WATCHDOG_KICK_EN
  logic [2:0] wd_q;

  // Each kick reloads the count, so a re-kick restarts the 4-cycle pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          wd_q <= '0;
    else if (wd_kick)      wd_q <= 3'd4;
    else if (wd_q != 3'd0) wd_q <= wd_q - 3'd1;
  end

  assign RU_nRSTIMER = (wd_q != 3'd0);
`else
  assign RU_nRSTIMER = 1'b0;
`endif

endmodule

// File: tb/tb_dual_config_ctrl.sv
// Randomized command bench for dual_config_ctrl; expected pin phases come from a per-command timeline model.
module tb_dual_config_ctrl;
  logic        clk = 1'b0;
  logic        reset_n, cmd_valid, rsp_ready, RU_DOUT, wd_kick;
  logic [1:0]  cmd_op, cmd_sel;
  logic        cmd_ready, rsp_valid, rsp_err, busy;
  logic [3:0]  rsp_data;
  logic        RU_CLK, RU_DIN, RU_SHIFTnLD, RU_CAPTnUPDT, RU_nCONFIG, RU_nRSTIMER;
  int          nvec = 0, nerr = 0, wd_left = 0;

  localparam logic [7:0] P_IDLE = 8'b1000_0100;
  localparam logic [7:0] P_CAPT = 8'b0100_0100;
  localparam logic [7:0] P_RSH  = 8'b0100_1100;
  localparam logic [7:0] P_UPDT = 8'b0100_0000;
  localparam logic [7:0] P_DLY  = 8'b0100_0100;
  localparam logic [7:0] P_NCFG = 8'b0100_0101;

  dual_config_ctrl dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .RU_CLK(RU_CLK), .RU_DIN(RU_DIN),
    .RU_SHIFTnLD(RU_SHIFTnLD), .RU_CAPTnUPDT(RU_CAPTnUPDT), .RU_nCONFIG(RU_nCONFIG),
    .RU_nRSTIMER(RU_nRSTIMER), .RU_DOUT(RU_DOUT)
`ifdef WATCHDOG_KICK_EN
    , .wd_kick(wd_kick)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] pins();
    return {cmd_ready, busy, rsp_valid, rsp_err, RU_SHIFTnLD, RU_CAPTnUPDT, RU_DIN, RU_nCONFIG, RU_nRSTIMER};
  endfunction

  // e = {cmd_ready,busy,rsp_valid,rsp_err,SHIFTnLD,CAPTnUPDT,DIN,nCONFIG}; timer bit from the kick model.
  task automatic chk_pins(string tag, logic [7:0] e);
    chk(tag, 64'(pins()), 64'({e, 1'(wd_left > 0)}));
    chk({tag, "_ruclk"}, 64'(RU_CLK), 64'(!clk));
  endtask

  task automatic cyc();
    logic k;
    k = wd_kick;
    @(posedge clk);
    if (k) wd_left = 4;
    else if (wd_left > 0) wd_left--;
    @(negedge clk);
    wd_kick = 1'b0;
  endtask

  task automatic noise();
    cmd_valid = 1'($urandom);
    cmd_op    = 2'($urandom);
    cmd_sel   = 2'($urandom);
    rsp_ready = 1'($urandom);
  endtask

  task automatic resp(logic [3:0] d, logic e, int hold);
    for (int h = 0; h <= hold; h++) begin
      chk_pins("resp", {3'b011, e, 4'b0100});
      chk("rsp_data", 64'(rsp_data), 64'(d));
      noise();
      rsp_ready = (h == hold);
      cyc();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk_pins("resp_done", P_IDLE);
  endtask

  task automatic do_cmd(logic [1:0] op, logic [1:0] sel, logic [40:0] word, int kick_at, int hold, bit abort);
    logic [40:0] w;
    chk_pins("idle", P_IDLE);
    cmd_valid = 1'b1; cmd_op = op; cmd_sel = sel; rsp_ready = 1'($urandom);
    cyc();
    if (op == 2'b11) begin
      resp(4'd0, 1'b1, hold);
      return;
    end
    if (op == 2'b00) begin
      chk_pins("capt", P_CAPT);
      noise(); RU_DOUT = 1'($urandom);
      cyc();
    end
    w = 41'(sel) << 12;
    for (int i = 0; i < 41; i++) begin
      if (op == 2'b00) chk_pins("rd_shift", P_RSH);
      else             chk_pins("wr_shift", {6'b010010, w[i], 1'b0});
      noise();
      RU_DOUT = word[i];
      if (i == kick_at) wd_kick = 1'b1;
      cyc();
    end
    RU_DOUT = 1'($urandom);
    if (op == 2'b00) begin
      resp(4'((word >> 30) & 41'hF), 1'b0, hold);
      return;
    end
    chk_pins("updt", P_UPDT);
    noise();
    cyc();
    if (op == 2'b01) begin
      resp(4'd0, 1'b0, hold);
      return;
    end
    for (int j = 0; j < 7; j++) begin
      chk_pins("dly", P_DLY);
      noise();
      cyc();
    end
    for (int j = 0; j < 16; j++) begin
      chk_pins("ncfg", P_NCFG);
      noise();
      if (abort && j == 2) begin
        #2 reset_n = 1'b0;
        wd_left = 0;
        #1 chk_pins("rst_async", P_IDLE);
        cmd_valid = 1'b0; wd_kick = 1'b0;
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk_pins("rst_after", P_IDLE);
        return;
      end
      cyc();
    end
    cmd_valid = 1'b0;
    chk_pins("post_ncfg", P_IDLE);
  endtask

  initial begin
    logic [40:0] word;
    logic [1:0]  op;
    int          kick_at;
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_sel = '0;
    rsp_ready = 1'b0; RU_DOUT = 1'b0; wd_kick = 1'b0;
    repeat (3) @(negedge clk);
    chk_pins("reset", P_IDLE);
    chk("reset_data", 64'(rsp_data), 64'd0);
    @(posedge clk);
    #1 chk("ru_clk_hi", 64'(RU_CLK), 64'(!clk));
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    word = 41'({$urandom, $urandom});
    word[33:30] = 4'b1010;
    do_cmd(2'b00, 2'b00, word, -1, 2, 1'b0);
    chk("dir_read_seen", 64'((word >> 30) & 41'hF), 64'hA);
    do_cmd(2'b01, 2'b10, '0, -1, 0, 1'b0);
    do_cmd(2'b10, 2'b01, '0, -1, 0, 1'b0);
    do_cmd(2'b11, 2'b00, '0, -1, 5, 1'b0);
    do_cmd(2'b10, 2'b11, '0, -1, 0, 1'b1);
`ifdef WATCHDOG_KICK_EN
    word = 41'({$urandom, $urandom});
    do_cmd(2'b00, 2'b00, word, 10, 1, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      op   = 2'($urandom);
      word = 41'({$urandom, $urandom});
`ifdef WATCHDOG_KICK_EN
      kick_at = ($urandom % 2) ? int'($urandom % 41) : -1;
`else
      kick_at = -1;
`endif
      do_cmd(op, 2'($urandom), word, kick_at, int'($urandom % 4), (op == 2'b10) && ($urandom % 4 == 0));
    end
    repeat (5) cyc();
    chk_pins("final", P_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/dual_config_ctrl.md
DUAL_CONFIG_CTRL -- requirements
Module: dual_config_ctrl

Interface
REQ-001 The block SHALL have parameters: REG_W, default 41, remote-update shift register length; SEL_LSB, default 12, bit position of the image-select field; SEL_W, default 2, width of the image-select field; RD_LSB, default 30, bit position of the status read field; RD_W, default 4, width of the status read field; NC_DLY, default 7, idle cycles between update and nCONFIG; NC_LEN, default 16, width of the nCONFIG pulse in cycles.
REQ-002 Ports SHALL be, as name direction width meaning:
- clk in 1: single clock.
- reset_n in 1: asynchronous active-low reset.
- cmd_valid in 1: command offered.
- cmd_ready out 1: command accepted when high together with cmd_valid.
- cmd_op in 2: 00 read, 01 write, 10 write+reconfig, 11 illegal.
- cmd_sel in SEL_W: image select for write.
- rsp_valid out 1: response held until taken.
- rsp_ready in 1: response consumed.
- rsp_data out RD_W: read result, 0 for write.
- rsp_err out 1: illegal op.
- busy out 1: not IDLE.
- RU_CLK, RU_DIN, RU_SHIFTnLD, RU_CAPTnUPDT, RU_nCONFIG, RU_nRSTIMER out 1: remote-update block pins.
- RU_DOUT in 1: remote-update block pin.
REQ-003 Clocking SHALL be one clock with asynchronous active-low reset (clk, reset_n).

Function
REQ-004 RU_CLK SHALL equal the inverse of clk, so the remote-update block samples mid-cycle.
REQ-005 The FSM states SHALL be IDLE, CAPT, SHIFT, UPDT, DLY, NCFG and RESP.
REQ-006 cmd_ready SHALL be high only in IDLE; busy SHALL be high in every other state.
REQ-007 A command SHALL be accepted on a clk edge where cmd_valid and cmd_ready are both high; cmd_op and cmd_sel SHALL be latched on that edge.
REQ-008 A read SHALL go IDLE->CAPT (1 cycle: RU_SHIFTnLD=0, RU_CAPTnUPDT=1) ->SHIFT (REG_W cycles: RU_SHIFTnLD=1, RU_CAPTnUPDT=1, RU_DOUT shifted in LSB-first on each clk edge) ->RESP.
REQ-009 A read SHALL set rsp_data to bits [RD_LSB+RD_W-1:RD_LSB] of the assembled REG_W-bit word.
REQ-010 A write or write+reconfig SHALL preload the word with zeros except cmd_sel at [SEL_LSB+SEL_W-1:SEL_LSB], then go IDLE->SHIFT (REG_W cycles, RU_SHIFTnLD=1, RU_CAPTnUPDT=0, RU_DIN=word LSB-first) ->UPDT (1 cycle, RU_SHIFTnLD=0, RU_CAPTnUPDT=0).
REQ-011 After UPDT, a write SHALL go to RESP with rsp_data=0.
REQ-012 After UPDT, a write+reconfig SHALL go to DLY for NC_DLY cycles, then NCFG for NC_LEN cycles with RU_NCONFIG=1, then IDLE with no response.
REQ-013 Op 11 SHALL go directly to RESP with rsp_err=1 and rsp_data=0, with no RU pin activity.
REQ-014 In RESP, rsp_valid SHALL be 1 with rsp_data and rsp_err stable; the transition to IDLE SHALL occur on the edge where rsp_ready=1.
REQ-015 rsp_ready SHALL be ignored outside RESP.
REQ-016 Outside CAPT, SHIFT and UPDT, RU_SHIFTnLD SHALL be 0, RU_CAPTnUPDT SHALL be 1 and RU_DIN SHALL be 0.
REQ-017 RU_nCONFIG SHALL be 0 outside NCFG.
REQ-018 cmd_valid while busy SHALL have no effect and SHALL not be queued.
REQ-019 Internal counters SHALL be sized $clog2(max(REG_W,NC_DLY,NC_LEN)+1) bits and SHALL never wrap.

Reset
REQ-020 While reset_n=0, the state SHALL be IDLE and all counters and shift registers SHALL be 0.
REQ-021 While reset_n=0, outputs SHALL be: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, busy=0, RU_DIN=0, RU_SHIFTnLD=0, RU_CAPTnUPDT=1, RU_nCONFIG=0, RU_nRSTIMER=0.
REQ-022 Reset asserted mid-operation, including during NCFG, SHALL abort immediately with no response and RU_nCONFIG low.

Configuration
REQ-023 With WATCHDOG_KICK_EN defined, a 1-bit input wd_kick SHALL exist; a wd_kick high for one cycle SHALL drive RU_nRSTIMER=1 for exactly 4 cycles starting the next cycle, independent of the FSM, and a re-kick during the pulse SHALL restart the 4-cycle count.
REQ-024 Without WATCHDOG_KICK_EN, wd_kick SHALL be absent and RU_nRSTIMER SHALL be tied to 0.

Verification
REQ-025 With defaults, a read with RU_DOUT driving word bits[33:30]=4'b1010 SHALL give 1 CAPT + 41 SHIFT cycles, then rsp_valid=1, rsp_data=4'hA, rsp_err=0.
REQ-026 A write with cmd_sel=2'b10 SHALL put RU_DIN=1 only on SHIFT cycle 14 (1-based), follow with 1 UPDT cycle, then rsp_valid=1 and rsp_data=0.
REQ-027 A write+reconfig SHALL give 41 SHIFT cycles, 1 UPDT, 7 idle cycles, RU_nCONFIG=1 for 16 cycles, then IDLE with no rsp_valid.
REQ-028 Op 11 SHALL produce rsp_valid on the cycle after accept with rsp_err=1, and with rsp_ready held 0 for 5 cycles rsp_valid SHALL stay 1 and cmd_ready SHALL stay 0.
REQ-029 reset_n pulsed low at NCFG cycle 3 SHALL drop RU_nCONFIG to 0 asynchronously and return the block to IDLE with cmd_ready=1.
REQ-030 With WATCHDOG_KICK_EN, wd_kick pulsed during SHIFT SHALL give RU_nRSTIMER high for exactly 4 cycles with read data unaffected.
